axis_uart_deframer: RTL and testbench

//  Consumes the byte stream from the UART receiver (AXI-Stream, 8-bit) and extracts framed packets:
//  SOF, LEN, LEN payload bytes, CHK. Emits payload bytes downstream with tlast on the final byte
//  and tuser flagging a bad frame. Sits between the UART RX stage and the command/register logic.

---
 rtl/axis_uart_deframer_pkg.sv | 22 ++
 rtl/axis_uart_deframer_if.sv | 13 +
 rtl/axis_uart_deframer_gap_timer.sv | 42 ++++
 rtl/axis_uart_deframer.sv | 202 ++++++++++++++++++++
 tb/tb_axis_uart_deframer.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_uart_deframer_pkg.sv
// Shared types and helpers for the UART byte-stream deframer.
//   deframer_state_e : deframer FSM state encoding
//   DEFAULT_SOF      : default start-of-frame marker
//   char_time()      : clock cycles per 10-bit UART character
package uart_frame_pkg;

   typedef enum logic [2:0] {
      HUNT    = 3'd0,
      LEN     = 3'd1,
      PAYLOAD = 3'd2,
      CHK     = 3'd3,
      ABORT   = 3'd4
   } deframer_state_e;

   localparam logic [7:0] DEFAULT_SOF = 8'hA5;

   function automatic int unsigned char_time(input int unsigned clock_hz,
                                             input int unsigned baud);
      return (clock_hz / baud) * 10;
   endfunction

endpackage

// File: rtl/axis_uart_deframer_if.sv
// Minimal AXI-Stream bundle (data, valid, ready).
//   s_axis : consumer side (tdata/tvalid in, tready out)
//   m_axis : producer side (tdata/tvalid out, tready in)
interface axis_if #(
   parameter int W = 8
);
   logic [W-1:0] tdata;
   logic         tvalid;
   logic         tready;

   modport s_axis (input tdata, input tvalid, output tready);
   modport m_axis (output tdata, output tvalid, input tready);
endinterface

// File: rtl/axis_uart_deframer_gap_timer.sv
// Inter-byte gap timer: down-counter with terminal-count flag.
//   aclk, aresetn : clock, async active-low reset
//   run           : count while high, otherwise held at zero
//   load          : reload to LIMIT (takes priority over run)
//   expired       : counter at terminal count (zero)
module uart_gap_timer #(
   parameter int unsigned LIMIT = 400
) (
   input  logic aclk,
   input  logic aresetn,
   input  logic run,
   input  logic load,
   output logic expired
);

   localparam int W = $clog2(LIMIT + 1);
   localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = LIMIT_V;
      end else if (!run) begin
         cnt_d = '0;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/axis_uart_deframer.sv
// Extracts SOF/LEN/payload/CHK frames from a UART byte stream and forwards
// the payload downstream with tlast on the final byte and tuser marking a
// bad frame (checksum error or inter-byte timeout).
//   aclk, aresetn        : clock, async active-low reset
//   s_axis               : incoming byte stream
//   m_tdata/m_tvalid/... : payload stream out (m_tuser valid with m_tlast)
//   frame_ok, frame_err  : one-cycle completion pulses
//
// state   | meaning
// HUNT    | discard bytes until SOF
// LEN     | expect length byte
// PAYLOAD | collecting payload bytes
// CHK     | expect checksum byte; releases the held final byte
// ABORT   | gap timeout; flush held byte as bad tail, then HUNT
module axis_uart_deframer
   import uart_frame_pkg::*;
#(
   parameter int unsigned CLOCK         = 100_000_000,
   parameter int unsigned BAUD_RATE     = 115_200,
   parameter logic [7:0]  SOF_BYTE      = DEFAULT_SOF,
   parameter int unsigned MAX_LEN       = 64,
   parameter int unsigned TIMEOUT_CHARS = 4
) (
   input  logic       aclk,
   input  logic       aresetn,
   axis_if.s_axis     s_axis,
   output logic [7:0] m_tdata,
   output logic       m_tvalid,
   input  logic       m_tready,
   output logic       m_tlast,
   output logic       m_tuser,
   output logic       frame_ok,
   output logic       frame_err
);

   localparam int unsigned TO_LIMIT  = TIMEOUT_CHARS * char_time(CLOCK, BAUD_RATE);
   localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

   deframer_state_e state_q, state_d;
   logic [7:0] hold_data_q, hold_data_d;
   logic       hold_full_q, hold_full_d;
   logic [7:0] xor_q, xor_d;
   logic [7:0] remain_q, remain_d;
   logic [7:0] out_data_q, out_data_d;
   logic       out_valid_q, out_valid_d;
   logic       out_last_q, out_last_d;
   logic       out_user_q, out_user_d;
   logic       ok_q, ok_d;
   logic       err_q, err_d;

   logic s_tready;
   logic s_acc;
   logic out_free;
   logic timer_run;
   logic timer_expired;
   logic [7:0] s_byte;

   assign s_byte   = s_axis.tdata;
   assign out_free = !out_valid_q || m_tready;

   // Payload-side states only take a byte when the output register can absorb
   // the hold byte that the new byte displaces.
   assign s_tready = (state_q == HUNT) || (state_q == LEN) ||
                     (((state_q == PAYLOAD) || (state_q == CHK)) && out_free);
   assign s_axis.tready = s_tready;
   assign s_acc         = s_axis.tvalid && s_tready;

   assign timer_run = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHK);

   uart_gap_timer #(
      .LIMIT (TO_LIMIT)
   ) u_gap_timer (
      .aclk    (aclk),
      .aresetn (aresetn),
      .run     (timer_run),
      .load    (s_acc),
      .expired (timer_expired)
   );

   always_comb begin
      state_d     = state_q;
      hold_data_d = hold_data_q;
      hold_full_d = hold_full_q;
      xor_d       = xor_q;
      remain_d    = remain_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q && !m_tready;
      out_last_d  = out_last_q;
      out_user_d  = out_user_q;
      ok_d        = 1'b0;
      err_d       = 1'b0;

      case (state_q)
         HUNT: begin
            if (s_acc && (s_byte == SOF_BYTE)) begin
               state_d = LEN;
            end
         end
         LEN: begin
            if (s_acc) begin
               if ((s_byte == 8'd0) || (s_byte > MAX_LEN_B)) begin
                  err_d   = 1'b1;
                  state_d = HUNT;
               end else begin
                  xor_d    = s_byte;
                  remain_d = s_byte;
                  state_d  = PAYLOAD;
               end
            end else if (timer_expired) begin
               err_d   = 1'b1;
               state_d = HUNT;
            end
         end
         PAYLOAD: begin
            if (s_acc) begin
               xor_d    = xor_q ^ s_byte;
               remain_d = remain_q - 8'd1;
               if (hold_full_q) begin
                  out_valid_d = 1'b1;
                  out_data_d  = hold_data_q;
                  out_last_d  = 1'b0;
                  out_user_d  = 1'b0;
               end
               hold_data_d = s_byte;
               hold_full_d = 1'b1;
               if (remain_q == 8'd1) begin
                  state_d = CHK;
               end
            end else if (timer_expired) begin
               state_d = ABORT;
            end
         end
         CHK: begin
            if (s_acc) begin
               out_valid_d = 1'b1;
               out_data_d  = hold_data_q;
               out_last_d  = 1'b1;
               out_user_d  = (s_byte != xor_q);
               hold_full_d = 1'b0;
               ok_d        = (s_byte == xor_q);
               err_d       = (s_byte != xor_q);
               state_d     = HUNT;
            end else if (timer_expired) begin
               state_d = ABORT;
            end
         end
         ABORT: begin
            if (!hold_full_q) begin
               err_d   = 1'b1;
               state_d = HUNT;
            end else if (out_free) begin
               out_valid_d = 1'b1;
               out_data_d  = hold_data_q;
               out_last_d  = 1'b1;
               out_user_d  = 1'b1;
               hold_full_d = 1'b0;
               err_d       = 1'b1;
               state_d     = HUNT;
            end
         end
         default: begin
            state_d = HUNT;
         end
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= HUNT;
         hold_data_q <= 8'd0;
         hold_full_q <= 1'b0;
         xor_q       <= 8'd0;
         remain_q    <= 8'd0;
         out_data_q  <= 8'd0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_user_q  <= 1'b0;
         ok_q        <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_data_q <= hold_data_d;
         hold_full_q <= hold_full_d;
         xor_q       <= xor_d;
         remain_q    <= remain_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_user_q  <= out_user_d;
         ok_q        <= ok_d;
         err_q       <= err_d;
      end
   end

   assign m_tdata   = out_data_q;
   assign m_tvalid  = out_valid_q;
   assign m_tlast   = out_last_q;
   assign m_tuser   = out_user_q;
   assign frame_ok  = ok_q;
   assign frame_err = err_q;

endmodule

// File: tb/tb_axis_uart_deframer.sv
module tb_axis_uart_deframer;
   import uart_frame_pkg::*;

   localparam int unsigned CLK_HZ = 1_000_000;
   localparam int unsigned BAUD   = 100_000;
   localparam int unsigned MAXL   = 64;
   localparam int unsigned TOC    = 4;
   localparam int unsigned TO_CYC = TOC * 10 * (CLK_HZ / BAUD);
   localparam logic [7:0]  SOF    = 8'hA5;

   logic aclk    = 1'b0;
   logic aresetn = 1'b1;
   always #5 aclk = ~aclk;

   axis_if s_if ();

   logic [7:0] m_tdata;
   logic       m_tvalid;
   logic       m_tready;
   logic       m_tlast;
   logic       m_tuser;
   logic       frame_ok;
   logic       frame_err;

   axis_uart_deframer #(
      .CLOCK         (CLK_HZ),
      .BAUD_RATE     (BAUD),
      .SOF_BYTE      (SOF),
      .MAX_LEN       (MAXL),
      .TIMEOUT_CHARS (TOC)
   ) dut (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .s_axis    (s_if),
      .m_tdata   (m_tdata),
      .m_tvalid  (m_tvalid),
      .m_tready  (m_tready),
      .m_tlast   (m_tlast),
      .m_tuser   (m_tuser),
      .frame_ok  (frame_ok),
      .frame_err (frame_err)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int n_ok  = 0;
   int n_err = 0;
   int rdy_mode = 0;  // 0: always ready, 1: random, 2: held low
   int exp_ok;
   int exp_err;
   logic [9:0] got_q[$];
   logic [9:0] exp_q[$];
   logic [7:0] stim_q[$];

   // Downstream ready driver
   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge aclk);
         #1;
         case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ($urandom_range(0, 2) != 0);
            default: m_tready = 1'b0;
         endcase
      end
   end

   // Output beat and pulse monitor
   always @(negedge aclk) begin
      if (aresetn) begin
         if (m_tvalid && m_tready) got_q.push_back({m_tdata, m_tlast, m_tuser});
         if (frame_ok)  n_ok++;
         if (frame_err) n_err++;
      end
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Frame-level reference: buffers each whole payload and emits it when CHK arrives.
   function automatic void model();
      int st = 0;
      int len = 0;
      logic [7:0] x = 8'd0;
      logic [7:0] pay[$];
      logic [7:0] b;
      exp_q.delete();
      exp_ok  = 0;
      exp_err = 0;
      foreach (stim_q[i]) begin
         b = stim_q[i];
         case (st)
            0: if (b == SOF) st = 1;
            1: begin
               if ((b == 8'd0) || (int'(b) > MAXL)) begin
                  exp_err++;
                  st = 0;
               end else begin
                  len = int'(b);
                  x = b;
                  pay.delete();
                  st = 2;
               end
            end
            2: begin
               pay.push_back(b);
               x = x ^ b;
               if (pay.size() == len) st = 3;
            end
            default: begin
               for (int k = 0; k < len; k++)
                  exp_q.push_back({pay[k], (k == len - 1), ((k == len - 1) && (b != x))});
               if (b == x) exp_ok++;
               else exp_err++;
               st = 0;
            end
         endcase
      end
   endfunction

   task automatic push_frame(input int len, input bit good);
      logic [7:0] x;
      logic [7:0] d;
      x = 8'(len);
      stim_q.push_back(SOF);
      stim_q.push_back(8'(len));
      for (int i = 0; i < len; i++) begin
         d = 8'($urandom);
         x = x ^ d;
         stim_q.push_back(d);
      end
      stim_q.push_back(good ? x : (x ^ 8'(1 << $urandom_range(0, 7))));
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      s_if.tdata  = b;
      s_if.tvalid = 1'b1;
      forever begin
         @(negedge aclk);
         if (s_if.tready) begin
            @(posedge aclk);
            #1;
            break;
         end
         n++;
         if (n > 2000) begin
            check("send_tready", 32'(s_if.tready), 32'd1);
            break;
         end
      end
      s_if.tvalid = 1'b0;
   endtask

   task automatic drain();
      rdy_mode = 0;
      for (int i = 0; i < 200 && m_tvalid; i++) @(negedge aclk);
      if (m_tvalid) check("drain_valid", 32'(m_tvalid), 32'd0);
      repeat (3) @(negedge aclk);
      @(posedge aclk);
      #1;
   endtask

   task automatic check_stream(input string tag, input int ok0, input int err0);
      model();
      check({tag, "_beats"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("%s_beat%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      check({tag, "_ok"},  32'(n_ok - ok0),   32'(exp_ok));
      check({tag, "_err"}, 32'(n_err - err0), 32'(exp_err));
   endtask

   task automatic run_stim(input string tag, input bit gaps);
      int ok0;
      int err0;
      ok0  = n_ok;
      err0 = n_err;
      got_q.delete();
      foreach (stim_q[i]) begin
         send_byte(stim_q[i]);
         if (gaps) repeat ($urandom_range(0, 2)) begin
            @(posedge aclk);
            #1;
         end
      end
      drain();
      check_stream(tag, ok0, err0);
      stim_q.delete();
   endtask

   initial begin
      int ok0;
      int err0;
      int waited;
      int kind;

      s_if.tdata  = 8'd0;
      s_if.tvalid = 1'b0;
      #1 aresetn = 1'b0;
      repeat (3) @(negedge aclk);
      check("rst_m_tvalid",  32'(m_tvalid),  32'd0);
      check("rst_m_tlast",   32'(m_tlast),   32'd0);
      check("rst_m_tuser",   32'(m_tuser),   32'd0);
      check("rst_m_tdata",   32'(m_tdata),   32'd0);
      check("rst_frame_ok",  32'(frame_ok),  32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_s_tready",  32'(s_if.tready), 32'd1);
      @(posedge aclk);
      #1 aresetn = 1'b1;
      repeat (2) @(posedge aclk);
      #1;

      // Good frame
      stim_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      run_stim("good3", 1'b0);

      // Bad checksum
      stim_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
      run_stim("badchk", 1'b0);

      // Garbage then single-byte frame
      stim_q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h7E, 8'h7F};
      run_stim("garbage", 1'b0);

      // Illegal lengths (0, MAX_LEN+1, SOF as length) then a good frame
      stim_q = '{8'hA5, 8'h00, 8'hA5, 8'h41, 8'hA5, 8'hA5,
                 8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
      run_stim("badlen", 1'b0);

      // Largest legal length
      push_frame(MAXL, 1'b1);
      run_stim("maxlen", 1'b0);

      // Timeout mid-payload
      ok0  = n_ok;
      err0 = n_err;
      got_q.delete();
      send_byte(8'hA5);
      send_byte(8'h04);
      send_byte(8'h01);
      send_byte(8'h02);
      waited = 0;
      while (waited < 3 * int'(TO_CYC) && n_err == err0) begin
         @(negedge aclk);
         waited++;
      end
      check("to_err", 32'(n_err - err0), 32'd1);
      check("to_not_early", 32'(waited >= int'(TO_CYC)), 32'd1);
      check("to_not_late", 32'(waited <= int'(TO_CYC) + 10), 32'd1);
      drain();
      check("to_beats", 32'(got_q.size()), 32'd2);
      check("to_beat0", 32'(got_q[0]), 32'({8'h01, 1'b0, 1'b0}));
      check("to_beat1", 32'(got_q[1]), 32'({8'h02, 1'b1, 1'b1}));
      check("to_ok", 32'(n_ok - ok0), 32'd0);
      check("to_hunt_tready", 32'(s_if.tready), 32'd1);

      // Downstream stall mid-frame
      rdy_mode = 2;
      repeat (2) @(posedge aclk);
      #1;
      ok0  = n_ok;
      err0 = n_err;
      got_q.delete();
      stim_q = '{8'hA5, 8'h05, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h05 ^ 8'h10 ^ 8'h20 ^ 8'h30 ^ 8'h40 ^ 8'h50};
      for (int i = 0; i < 4; i++) send_byte(stim_q[i]);
      s_if.tdata  = 8'h30;
      s_if.tvalid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge aclk);
         check("stall_s_tready", 32'(s_if.tready), 32'd0);
         check("stall_m_tvalid", 32'(m_tvalid), 32'd1);
         check("stall_m_tdata",  32'(m_tdata),  32'h10);
      end
      rdy_mode = 0;
      for (int i = 4; i < stim_q.size(); i++) send_byte(stim_q[i]);
      drain();
      check_stream("stall", ok0, err0);
      stim_q.delete();

      // Randomized mix under random backpressure
      for (int r = 0; r < 3; r++) begin
         for (int f = 0; f < 12; f++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 5) begin
               push_frame($urandom_range(1, MAXL), 1'b1);
            end else if (kind <= 7) begin
               push_frame($urandom_range(1, 16), 1'b0);
            end else if (kind == 8) begin
               stim_q.push_back(SOF);
               stim_q.push_back(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAXL + 1, 255)));
            end else begin
               repeat ($urandom_range(1, 3)) stim_q.push_back(8'($urandom_range(0, 8'hA4)));
            end
         end
         rdy_mode = 1;
         run_stim($sformatf("rand%0d", r), 1'b1);
      end

      // Reset mid-frame discards the partial frame
      send_byte(8'hA5);
      send_byte(8'h03);
      send_byte(8'h11);
      #1 aresetn = 1'b0;
      @(negedge aclk);
      check("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
      check("midrst_s_tready", 32'(s_if.tready), 32'd1);
      @(posedge aclk);
      #1 aresetn = 1'b1;
      @(posedge aclk);
      #1;
      stim_q = '{8'hA5, 8'h02, 8'hAB, 8'hCD, 8'h02 ^ 8'hAB ^ 8'hCD};
      run_stim("after_rst", 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
